// File: rtl/vga_image_fetch.sv
// vga_image_fetch: VGA timing generator and image reader. Scans the screen, drives the
// read address into data memory and turns the returned byte into a grayscale pixel.
// The IMG_W x IMG_H image sits at the top-left of the screen. The rest of the visible
// area is painted with BORDER_COLOR.
// Latency: 2 pix_ce steps from a counter value to the matching pixel_out/hsync/vsync/video_on.
// Backpressure: none. pix_ce paces the whole pipeline, and with pix_ce low every register
// holds. frame_start is the one exception: it is a single-clk pulse.
// Ports:
//   clk, rst_n      clock and async active-low reset
//   pix_ce          pixel clock enable
//   ImageData       byte read back from data memory at vgaAdress
//   vgaAdress       image read address (holds its value outside the image)
//   pixel_out       grayscale pixel (0 while blanking)
//   hsync, vsync    active-low syncs, aligned with pixel_out
//   video_on        pixel_out is in the visible area
//   frame_start     pulse when the counters wrap to (0,0)
module vga_image_fetch #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter logic [31:0] IMG_BASE     = 32'd0,
  parameter logic [7:0]  BORDER_COLOR = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  input  logic [7:0]  ImageData,
  output logic [31:0] vgaAdress,
  output logic [7:0]  pixel_out,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_IMG    = HW'(IMG_W);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_IMG    = VW'(IMG_H);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [31:0]   ROW_STEP = 32'(IMG_W);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [31:0]   row_base;    // address of pixel (0, v_cnt); stepped once per image line
  logic          in_img_d;
  logic          visible_d;
  logic          hsync_d;
  logic          vsync_d;

  logic h_last, v_last, in_img, visible, hsync_c, vsync_c;

  assign h_last  = (h_cnt == H_LAST);
  assign v_last  = (v_cnt == V_LAST);
  assign in_img  = (h_cnt < H_IMG) && (v_cnt < V_IMG);
  assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hsync_c = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
  assign vsync_c = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      row_base    <= IMG_BASE;
      vgaAdress   <= IMG_BASE;
      in_img_d    <= 1'b0;
      visible_d   <= 1'b0;
      hsync_d     <= 1'b1;
      vsync_d     <= 1'b1;
      pixel_out   <= 8'h00;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // frame_start is a pulse, so it is cleared on clks without pix_ce instead of holding.
      frame_start <= pix_ce && h_last && v_last;

      if (pix_ce) begin
        // Stage 0: raster counters.
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end

        // The row base is reloaded at frame wrap, so no error can build up from one frame
        // to the next. It only advances after lines that carried image data.
        if (h_last) begin
          if (v_last) begin
            row_base <= IMG_BASE;
          end else if (v_cnt < V_IMG) begin
            row_base <= row_base + ROW_STEP;
          end
        end

        // Stage 1: the address only moves inside the image, so no other reads reach memory.
        if (in_img) begin
          vgaAdress <= row_base + 32'(h_cnt);
        end
        in_img_d  <= in_img;
        visible_d <= visible;
        hsync_d   <= hsync_c;
        vsync_d   <= vsync_c;

        // Stage 2: by this point ImageData has settled for the registered address.
        if (in_img_d) begin
          pixel_out <= ImageData;
        end else if (visible_d) begin
          pixel_out <= BORDER_COLOR;
        end else begin
          pixel_out <= 8'h00;
        end
        hsync    <= hsync_d;
        vsync    <= vsync_d;
        video_on <= visible_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_image_fetch.sv
// Directed bench for vga_image_fetch. A reduced raster keeps the run short:
// 28 pixels per line (20 visible, FP 2, sync 3, BP 3) and 16 lines per frame
// (12 visible, FP 1, sync 2, BP 1), which gives 448 pix_ce per frame.
// The image is 8x6 at base 0x1000. The border is 0x5A, so it can be told apart from blanking.
// The memory model returns ImageData = addr[7:0] ^ addr[15:8].
// pix_ce pulses on every 2nd clk.
module tb_vga_image_fetch;
  localparam int FRAME = 448;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic [7:0]  image_data;
  logic [31:0] vga_adress;
  logic [7:0]  pixel_out;
  logic        hsync, vsync, video_on, frame_start;

  int compared = 0;
  int mismatched = 0;
  int pos = 0;          // counter position within the frame, 0..447
  int clk_cnt = 0;
  int fs_clk = 0;
  logic fs_hit = 1'b0;
  logic fs_tail = 1'b0;
  logic [31:0] frame1 [FRAME];

  always #5 clk = ~clk;
  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  assign image_data = vga_adress[7:0] ^ vga_adress[15:8];

  vga_image_fetch #(
    .H_VISIBLE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .IMG_W(8), .IMG_H(6), .IMG_BASE(32'h0000_1000), .BORDER_COLOR(8'h5A)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .ImageData(image_data),
    .vgaAdress(vga_adress), .pixel_out(pixel_out), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .frame_start(frame_start)
  );

  // One pixel step: pix_ce high for one clk, then low for one clk.
  task automatic pix_step();
    pix_ce = 1'b1;
    @(posedge clk); #1;
    fs_hit = frame_start;
    if (frame_start) fs_clk = clk_cnt;
    pix_ce = 1'b0;
    @(posedge clk); #1;
    fs_tail = frame_start;
    pos = (pos + 1) % FRAME;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 2 * FRAME && pos != target; i++) pix_step();
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pos = 0;
    run_to(88);                    // output currently shows pixel (2,3)
    pix_ce = 1'b1;
    #2 rst_n = 1'b0;
    #1;                            // no clk edge yet: reset acts asynchronously
    compared++; if (pixel_out !== 8'h00) begin mismatched++; $display("FAIL reset_pixel: got %h expected 00", pixel_out); end
    compared++; if (vga_adress !== 32'h1000) begin mismatched++; $display("FAIL reset_addr: got %h expected 00001000", vga_adress); end
    compared++; if (hsync !== 1'b1) begin mismatched++; $display("FAIL reset_hsync: got %b expected 1", hsync); end
    compared++; if (vsync !== 1'b1) begin mismatched++; $display("FAIL reset_vsync: got %b expected 1", vsync); end
    compared++; if (video_on !== 1'b0) begin mismatched++; $display("FAIL reset_video_on: got %b expected 0", video_on); end
    compared++; if (frame_start !== 1'b0) begin mismatched++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    repeat (3) @(posedge clk);
    #1;
    compared++; if (vga_adress !== 32'h1000) begin mismatched++; $display("FAIL reset_hold_addr: got %h expected 00001000", vga_adress); end
    @(negedge clk);
    rst_n = 1'b1;
    pix_ce = 1'b0;
    pos = 0;
    n = 0;
    do begin
      pix_step();
      n++;
    end while (!fs_hit && n < 1000);
    compared++; if (n != FRAME) begin mismatched++; $display("FAIL first_frame_start: got %0d steps expected %0d", n, FRAME); end
  endtask

  task automatic test_sync();
    int t0, line_low, first_low, vs_low;
    t0 = fs_clk;
    line_low = 0; first_low = 0; vs_low = 0;
    for (int k = 1; k <= FRAME; k++) begin
      pix_step();
      if (!hsync && k >= 3 && k <= 30) line_low++;
      if (!hsync && first_low == 0) first_low = k;
      if (!vsync) vs_low++;
    end
    compared++; if (line_low != 3) begin mismatched++; $display("FAIL hsync_line_low: got %0d expected 3", line_low); end
    compared++; if (first_low != 24) begin mismatched++; $display("FAIL hsync_first_low: got %0d expected 24", first_low); end
    compared++; if (vs_low != 56) begin mismatched++; $display("FAIL vsync_low: got %0d expected 56", vs_low); end
    compared++; if (fs_clk - t0 != 2 * FRAME) begin mismatched++; $display("FAIL frame_period: got %0d clk expected %0d", fs_clk - t0, 2 * FRAME); end
    compared++; if ({fs_hit, fs_tail} !== 2'b10) begin mismatched++; $display("FAIL frame_start_width: got %b expected 10", {fs_hit, fs_tail}); end
  endtask

  task automatic test_image();
    run_to(59);                    // counters at (3,2)
    pix_step();
    compared++; if (vga_adress !== 32'h1013) begin mismatched++; $display("FAIL img_addr: got %h expected 00001013", vga_adress); end
    compared++; if (pixel_out !== 8'h02) begin mismatched++; $display("FAIL img_pixel_prev: got %h expected 02", pixel_out); end
    pix_step();                    // 2 pix_ce after (3,2): 0x13 ^ 0x10
    compared++; if (pixel_out !== 8'h03) begin mismatched++; $display("FAIL img_pixel: got %h expected 03", pixel_out); end
    compared++; if (video_on !== 1'b1) begin mismatched++; $display("FAIL img_video_on: got %b expected 1", video_on); end
  endtask

  task automatic test_border();
    run_to(72);                    // output shows pixel (14,2)
    compared++; if (pixel_out !== 8'h5A) begin mismatched++; $display("FAIL border_pixel: got %h expected 5a", pixel_out); end
    compared++; if (video_on !== 1'b1) begin mismatched++; $display("FAIL border_video_on: got %b expected 1", video_on); end
    compared++; if (vga_adress !== 32'h1017) begin mismatched++; $display("FAIL border_addr: got %h expected 00001017", vga_adress); end
    run_to(81);                    // output shows pixel (23,2), inside hsync
    compared++; if (hsync !== 1'b0) begin mismatched++; $display("FAIL sync_hsync: got %b expected 0", hsync); end
    run_to(83);                    // output shows pixel (25,2), back porch
    compared++; if (pixel_out !== 8'h00) begin mismatched++; $display("FAIL blank_pixel: got %h expected 00", pixel_out); end
    compared++; if (video_on !== 1'b0) begin mismatched++; $display("FAIL blank_video_on: got %b expected 0", video_on); end
    compared++; if (vga_adress !== 32'h1017) begin mismatched++; $display("FAIL blank_addr: got %h expected 00001017", vga_adress); end
  endtask

  task automatic test_hold();
    run_to(88);                    // pixel (2,3) out, address of (3,3) registered
    repeat (50) @(posedge clk);
    #1;
    compared++; if (vga_adress !== 32'h101B) begin mismatched++; $display("FAIL hold_addr: got %h expected 0000101b", vga_adress); end
    compared++; if (pixel_out !== 8'h0A) begin mismatched++; $display("FAIL hold_pixel: got %h expected 0a", pixel_out); end
    compared++; if ({hsync, vsync, video_on} !== 3'b111) begin mismatched++; $display("FAIL hold_syncs: got %b expected 111", {hsync, vsync, video_on}); end
    pix_step();
    compared++; if (pixel_out !== 8'h0B) begin mismatched++; $display("FAIL resume_pixel: got %h expected 0b", pixel_out); end
    compared++; if (vga_adress !== 32'h101C) begin mismatched++; $display("FAIL resume_addr: got %h expected 0000101c", vga_adress); end
  endtask

  task automatic test_frames();
    int diffs;
    run_to(0);
    for (int i = 0; i < FRAME; i++) begin
      pix_step();
      frame1[i] = vga_adress;
    end
    for (int i = 0; i < FRAME; i++) pix_step();
    diffs = 0;
    for (int i = 0; i < FRAME; i++) begin
      pix_step();
      if (vga_adress !== frame1[i]) diffs++;
    end
    compared++; if (frame1[0] !== 32'h1000) begin mismatched++; $display("FAIL frame_first_addr: got %h expected 00001000", frame1[0]); end
    compared++; if (frame1[28] !== 32'h1008) begin mismatched++; $display("FAIL frame_row1_addr: got %h expected 00001008", frame1[28]); end
    compared++; if (frame1[147] !== 32'h102F) begin mismatched++; $display("FAIL frame_last_addr: got %h expected 0000102f", frame1[147]); end
    compared++; if (frame1[199] !== 32'h102F) begin mismatched++; $display("FAIL frame_no_fetch: got %h expected 0000102f", frame1[199]); end
    compared++; if (diffs != 0) begin mismatched++; $display("FAIL frame3_vs_frame1: got %0d differing steps expected 0", diffs); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_image();
    test_border();
    test_hold();
    test_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
